// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter sharing one WIDTH-bit counter among N_REQ requesters
// Ports: clk, rstn (async active-low); req/op/load_data per requester;
//   gnt/gnt_id combinational one-hot grant and its index; count_reg, ovf registered.
// Build option: define COUNTER_ARBITER_SATURATE_EN to saturate instead of wrapping.
module counter_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req,
  input  logic [2*N_REQ-1:0]         op,
  input  logic [WIDTH*N_REQ-1:0]     load_data,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   gnt_id,
  output logic [WIDTH-1:0]           count_reg,
  output logic                       ovf
);
  localparam int IDW = $clog2(N_REQ);
  localparam logic [IDW:0] NR = (IDW+1)'(N_REQ);
  typedef enum logic [1:0] {OP_INCR, OP_DECR, OP_CLEAR, OP_LOAD} op_e;
`ifdef COUNTER_ARBITER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [IDW:0]     sum;
  logic             found;
  op_e              op_sel;
  logic [WIDTH-1:0] ld;
  // scan from the pointer upward, wrapping at N_REQ; reset masks every grant
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      sum = (sum >= NR) ? sum - NR : sum;
      if (!found && rstn && req[sum[IDW-1:0]]) begin
        found                = 1'b1;
        gnt[sum[IDW-1:0]]    = 1'b1;
        gnt_id               = sum[IDW-1:0];
      end
    end
  end
  always_comb begin
    op_sel  = op_e'(op[2*gnt_id +: 2]);
    ld      = load_data[WIDTH*gnt_id +: WIDTH];
    count_d = count_q;
    ovf_d   = 1'b0;
    ptr_d   = ptr_q;
    if (found) begin
      ptr_d = (gnt_id == IDW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
      case (op_sel)
        OP_INCR: begin
          ovf_d   = &count_q;
          count_d = (SAT && ovf_d) ? count_q : count_q + 1'b1;
        end
        OP_DECR: begin
          ovf_d   = ~|count_q;
          count_d = (SAT && ovf_d) ? count_q : count_q - 1'b1;
        end
        OP_CLEAR: count_d = '0;
        default:  count_d = ld;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  assign count_reg = count_q;
  assign ovf       = ovf_q;
endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Shares one WIDTH-bit counter among N_REQ requesters using a round-robin arbiter.
- Each requester presents a counter command (increment, decrement, clear or load) with a req/gnt handshake.
- At most one command executes per clock.
- Sits in front of the counter datapath and is the only block that drives its register.

Parameters:
WIDTH, 8, counter width in bits
N_REQ, 4, number of requesters (2..16)

Ports:
clk  input  1  system clock, rising-edge
rstn  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester command request, held high until granted
op  input  2*N_REQ  per-requester opcode; op[2i+1:2i] belongs to requester i
load_data  input  WIDTH*N_REQ  per-requester load value; slice i is [WIDTH*i +: WIDTH]
gnt  output  N_REQ  one-hot grant, combinational from req and priority pointer
gnt_id  output  $clog2(N_REQ)  index of the granted requester, valid when |gnt
count_reg  output  WIDTH  current counter value, registered
ovf  output  1  one-cycle pulse, registered, on wrap (or saturation attempt, see Optional Feature)

Behaviour:
- Reset: one clock, clk. rstn is asynchronous and active-low.
  - While rstn=0: count_reg=0, ovf=0, priority pointer=0, gnt=0, gnt_id=0. gnt is forced to 0 even if req is high.
  - Deassertion is sampled synchronously. The first grant is possible in the first cycle with rstn=1.
- Opcodes:
  - 00 INCR: count+1
  - 01 DECR: count-1
  - 10 CLEAR: count=0
  - 11 LOAD: count=load_data slice
- Arbitration (combinational, same cycle):
  - Scan from the pointer upward, modulo N_REQ. The first i with req[i]=1 gets gnt[i]=1.
  - No req gives gnt=0.
  - gnt_id encodes the winner.
- Handshake:
  - A command executes at the rising edge where req[i]&gnt[i]=1.
  - A requester may drop req before being granted; this is allowed and has no side effect.
  - A requester may keep req high for back-to-back commands. Each granted cycle is one command.
- Pointer: after a grant to i, pointer <= (i+1) mod N_REQ. With no grant, the pointer holds. This prevents starvation: a continuously requesting requester waits at most N_REQ-1 cycles.
- Latency: count_reg and ovf reflect the command one cycle after the grant edge (registered outputs). Only one command is applied per cycle, so simultaneous requests are serialised, never merged.
- Arithmetic is modulo 2^WIDTH:
  - INCR at 2^WIDTH-1 gives 0 and ovf=1 for one cycle.
  - DECR at 0 gives 2^WIDTH-1 and ovf=1.
  - CLEAR and LOAD never raise ovf.
- Idle cycles: count_reg holds and ovf=0.
- Reset mid-operation: an asynchronous rstn assertion overrides any pending grant. The command in flight is discarded and the counter returns to 0.
- Requests persisting across reset are re-arbitrated from pointer 0 after release.

Optional Feature:
- Macro: COUNTER_ARBITER_SATURATE_EN.
- Defined:
  - INCR at 2^WIDTH-1 holds the value; DECR at 0 holds 0.
  - ovf pulses for one cycle on each such blocked attempt.
  - The command is still consumed: grant and pointer advance normally.
- Undefined: wrap-around behaviour as in Behaviour.
- CLEAR and LOAD are identical in both builds.

Test Plan:
- Reset check: rstn=0 with all req=1 -> gnt=0, count_reg=0, ovf=0. Release rstn -> gnt=0001 in the same cycle; count_reg=1 one cycle after the INCR edge.
- Round robin: N_REQ=4, req=1111 held with all INCR for 8 cycles -> grant order 0,1,2,3,0,1,2,3; count_reg=8.
- Mixed ops:
  - req0 LOAD 0x7F is granted -> count_reg=0x7F.
  - Then req2 DECR -> 0x7E.
  - Then req1 CLEAR -> 0x00.
  - Arbitration is from pointer 1 after the first grant.
- Wrap:
  - LOAD 0xFF, then INCR -> count_reg=0x00 with a 1-cycle ovf.
  - CLEAR, then DECR -> 0xFF with ovf=1.
  - With COUNTER_ARBITER_SATURATE_EN defined -> values hold at 0xFF and 0x00, ovf still pulses.
- Withdrawn request / idle: req3 raised while req0 is granted, then dropped before its grant -> no command from 3, count unchanged by it. Idle cycles: count holds, pointer holds.
- Mid-op reset: rstn pulsed low between clk edges during a granted INCR from count 0x10 -> count_reg=0 immediately (asynchronous). After release, the pointer restarts at 0.
